// File: rtl/bcd_pair_ctrl.sv
// Sequencer that pairs a serial BCD digit stream into tens/units for an external
// two-digit decoder, registers its result and hands it downstream with backpressure.
module bcd_pair_ctrl #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clear_i,
    input  logic [3:0]           digit_i,
    input  logic                 digit_valid_i,
    output logic                 digit_ready_o,
    output logic [3:0]           dec_tens_o,
    output logic [3:0]           dec_units_o,
    input  logic [6:0]           dec_number_i,
    input  logic                 dec_error_i,
    output logic [6:0]           number_o,
    output logic                 error_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        S_TENS,
        S_UNITS,
        S_CALC,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_TENS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        digit_ready_o = 1'b0;
        busy_o        = (state != S_TENS);
        case (state)
            S_TENS: begin
                digit_ready_o = 1'b1;
                if (digit_valid_i) state_nxt = S_UNITS;
            end
            S_UNITS: begin
                digit_ready_o = 1'b1;
                if (digit_valid_i) state_nxt = S_CALC;
            end
            S_CALC: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (ready_i) state_nxt = S_TENS;
            end
            default: state_nxt = S_TENS;
        endcase
        // Abort wins over any handshake in flight.
        if (clear_i) state_nxt = S_TENS;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dec_tens_o  <= '0;
            dec_units_o <= '0;
            number_o    <= '0;
            error_o     <= 1'b0;
            valid_o     <= 1'b0;
            err_cnt_o   <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else begin
            case (state)
                S_TENS: begin
                    if (digit_valid_i) dec_tens_o <= digit_i;
                end
                S_UNITS: begin
                    if (digit_valid_i) dec_units_o <= digit_i;
                end
                S_CALC: begin
                    // The decoder may float its number on error; force a clean zero instead.
                    error_o  <= dec_error_i;
                    number_o <= dec_error_i ? 7'd0 : dec_number_i;
                    valid_o  <= 1'b1;
                    if (dec_error_i && (err_cnt_o != {ERR_CNT_W{1'b1}}))
                        err_cnt_o <= err_cnt_o + 1'b1;
                end
                S_OUT: begin
                    if (ready_i) valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
